// File: rtl/alu_pkg.sv
`default_nettype none
// =====================================================================
// Package : alu_pkg
// Brief   : Opcodes, instruction layout and sequencer states for the ALU.
// Rev     : 1.0  initial release
// =====================================================================
package alu_pkg;

  localparam logic [3:0] OPC_ADD  = 4'b0000;
  localparam logic [3:0] OPC_SUB  = 4'b0001;
  localparam logic [3:0] OPC_AND  = 4'b0011;
  localparam logic [3:0] OPC_OR   = 4'b0100;
  localparam logic [3:0] OPC_XOR  = 4'b0101;
  localparam logic [3:0] OPC_NOT  = 4'b0110;
  localparam logic [3:0] OPC_HALT = 4'b1110;
  localparam logic [3:0] OPC_LDI  = 4'b1111;

  // For LDI, rs1 carries rd and {rs2, rd} carries the 8-bit immediate
  typedef struct packed {
    logic [3:0] opcode;
    logic [3:0] rs1;
    logic [3:0] rs2;
    logic [3:0] rd;
  } instr_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    FETCH = 2'd1,
    ISSUE = 2'd2,
    DONE  = 2'd3
  } state_t;

  // HALT counts as legal even though it is never issued
  function automatic logic is_legal(input logic [3:0] opc);
    case (opc)
      OPC_ADD, OPC_SUB, OPC_AND, OPC_OR, OPC_XOR,
      OPC_NOT, OPC_HALT, OPC_LDI: return 1'b1;
      default:                    return 1'b0;
    endcase
  endfunction

endpackage
`default_nettype wire

// File: rtl/prog_mem.sv
`default_nettype none
// =====================================================================
// Module : prog_mem
// Brief  : DEPTH x 16 program RAM, single write port, registered read.
// Rev    : 1.0  initial release
// =====================================================================
module prog_mem #(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          we,
  input  logic [AW-1:0] waddr,
  input  logic [15:0]   wdata,
  input  logic          re,
  input  logic [AW-1:0] raddr,
  output logic [15:0]   rdata
);

  logic [15:0] r_mem [DEPTH];
  logic [15:0] r_rdata;

  // Read data only moves on re, so it doubles as the held issue word
  always_ff @(posedge clk) begin
    if (we) r_mem[waddr] <= wdata;
    if (re) r_rdata      <= r_mem[raddr];
  end

  assign rdata = r_rdata;

endmodule
`default_nettype wire

// File: rtl/instr_issue_seq.sv
`default_nettype none
// =====================================================================
// Module : instr_issue_seq
// Brief  : Walks program memory and issues one ALU instruction per handshake.
// Rev    : 1.0  initial release
// =====================================================================
module instr_issue_seq
  import alu_pkg::*;
#(
  parameter int DEPTH = 16,
  parameter int AW    = $clog2(DEPTH)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          prog_we,
  input  logic [AW-1:0] prog_addr,
  input  logic [15:0]   prog_data,
  input  logic          start,
  input  logic          abort,
  output logic [15:0]   instr_out,
  output logic          instr_valid,
  input  logic          instr_ready,
  output logic          busy,
  output logic          done,
  output logic          err,
  output logic [AW-1:0] pc,
  output logic [AW:0]   issued_cnt
);

  localparam logic [AW-1:0] c_last_pc = AW'(DEPTH - 1);
  localparam logic [AW:0]   c_cnt_max = (AW + 1)'(DEPTH);

  state_t        r_state, w_state_nxt;
  logic [AW-1:0] r_pc;
  logic [AW:0]   r_cnt;
  logic          r_err;
  logic          r_loaded;
  logic [15:0]   w_rdata;
  logic [3:0]    w_opc;
  logic          w_idle_or_done;
  logic          w_mem_we;
  logic          w_start;
  logic          w_issuable;
  logic          w_accept;
  logic          w_illegal;

  assign w_idle_or_done = (r_state == IDLE) || (r_state == DONE);
  assign w_mem_we       = prog_we && w_idle_or_done;
  assign w_start        = start && !abort && w_idle_or_done;
  assign w_opc          = w_rdata[15:12];
  assign w_issuable     = (r_state == ISSUE) && is_legal(w_opc) && (w_opc != OPC_HALT);
  assign w_illegal      = (r_state == ISSUE) && !is_legal(w_opc);
  assign w_accept       = w_issuable && instr_ready && !abort;

  prog_mem #(
    .DEPTH (DEPTH),
    .AW    (AW)
  ) u_prog_mem (
    .clk   (clk),
    .we    (w_mem_we),
    .waddr (prog_addr),
    .wdata (prog_data),
    .re    (r_state == FETCH),
    .raddr (r_pc),
    .rdata (w_rdata)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE, DONE: if (w_start) w_state_nxt = FETCH;
      FETCH:      w_state_nxt = ISSUE;
      ISSUE: begin
        if (!w_issuable)   w_state_nxt = DONE;
        else if (w_accept) w_state_nxt = (r_pc == c_last_pc) ? DONE : FETCH;
      end
      default:    w_state_nxt = IDLE;
    endcase
    if (abort) w_state_nxt = IDLE;
  end

  // Abort leaves pc and err untouched so the host can inspect where it stopped
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc     <= '0;
      r_cnt    <= '0;
      r_err    <= 1'b0;
      r_loaded <= 1'b0;
    end else begin
      if (r_state == FETCH) r_loaded <= 1'b1;
      if (w_start) begin
        r_pc  <= '0;
        r_cnt <= '0;
        r_err <= 1'b0;
      end else begin
        if (w_accept && (r_pc != c_last_pc)) r_pc  <= r_pc + 1'b1;
        if (w_accept && (r_cnt != c_cnt_max)) r_cnt <= r_cnt + 1'b1;
        if (w_illegal && !abort)             r_err <= 1'b1;
      end
    end
  end

  // RAM output is unreset, so mask it until the first fetch has landed
  assign instr_out   = r_loaded ? w_rdata : 16'h0000;
  assign instr_valid = w_issuable;
  assign busy        = (r_state == FETCH) || (r_state == ISSUE);
  assign done        = (r_state == DONE);
  assign err         = r_err;
  assign pc          = r_pc;
  assign issued_cnt  = r_cnt;

endmodule
`default_nettype wire
